// File: rtl/alu10_pkg.sv
// Shared definitions for the alu10 execution-stage ALU: opcodes, flag bit
// positions and the saturation limits used when ALU_SAT_EN is defined.
package alu10_pkg;

    localparam int ALU_W = 10;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic signed [ALU_W-1:0] SAT_POS = {1'b0, {(ALU_W-1){1'b1}}};
    localparam logic signed [ALU_W-1:0] SAT_NEG = {1'b1, {(ALU_W-1){1'b0}}};

endpackage

// File: rtl/alu10_shifter.sv
// Combinational shift unit for alu10: SHL and SRA results with their
// carry (last bit shifted out) and, for SHL, the signed-overflow indication.
module alu10_shifter #(
    parameter int WIDTH = 10,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic        [SH_W-1:0]  shamt,
    output logic signed [WIDTH-1:0] shl_res,
    output logic                    shl_c,
    output logic                    shl_v,
    output logic signed [WIDTH-1:0] sra_res,
    output logic                    sra_c
);

    // Wide enough to hold A shifted by the largest encodable amount plus sign.
    localparam int EXT_W = WIDTH + (1 << SH_W);

    logic signed [EXT_W-1:0]     shl_ext;
    logic        [EXT_W-WIDTH:0] shl_top;
    logic signed [WIDTH:0]       sra_ext;

    // Shift in an extended domain so carry and overflow fall out as plain bits:
    // bit WIDTH of the SHL product is the last bit pushed out, and the extra
    // bit below A in the SRA path catches the last bit shifted out the bottom.
    always_comb begin
        shl_ext = {{(EXT_W-WIDTH){a[WIDTH-1]}}, a} <<< shamt;
        shl_top = shl_ext[EXT_W-1:WIDTH-1];
        shl_res = shl_ext[WIDTH-1:0];
        shl_c   = (shamt != '0) & shl_ext[WIDTH];
        shl_v   = ~((&shl_top) | ~(|shl_top));

        sra_ext = $signed({a, 1'b0}) >>> shamt;
        sra_res = sra_ext[WIDTH:1];
        sra_c   = sra_ext[0];
    end

endmodule

// File: rtl/alu10.sv
// alu10: registered WIDTH-bit signed ALU with {V,C,N,Z} flags, one-cycle
// latency, one operation per clock. Define ALU_SAT_EN to make ADD/SUB
// saturate on signed overflow instead of wrapping.
module alu10
    import alu10_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic signed [WIDTH-1:0] i_arg0,
    input  logic signed [WIDTH-1:0] i_arg1,
    input  logic        [2:0]       i_oper,
    output logic signed [WIDTH-1:0] o_result,
    output logic        [3:0]       o_flag
);

    localparam int SH_W = $clog2(WIDTH);

    logic        [WIDTH:0]   sum_w;
    logic        [WIDTH:0]   dif_w;
    logic signed [WIDTH-1:0] shl_res;
    logic signed [WIDTH-1:0] sra_res;
    logic                    shl_c;
    logic                    shl_v;
    logic                    sra_c;
    logic signed [WIDTH-1:0] res_c;
    logic                    c_c;
    logic                    v_c;
    logic        [3:0]       flag_c;
    logic signed [WIDTH-1:0] result_p1;
    logic        [3:0]       flag_p1;

    // Overflow always saturates toward the sign of A: for both ADD and SUB
    // a positive A can only overflow upward and a negative A downward.
    function automatic logic signed [WIDTH-1:0] sat_value(input logic a_sign);
        if (a_sign)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    alu10_shifter #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_shifter (
        .a       (i_arg0),
        .shamt   (i_arg1[SH_W-1:0]),
        .shl_res (shl_res),
        .shl_c   (shl_c),
        .shl_v   (shl_v),
        .sra_res (sra_res),
        .sra_c   (sra_c)
    );

    // Unsigned WIDTH+1 sums give carry-out and borrow directly in the top bit.
    assign sum_w = {1'b0, i_arg0} + {1'b0, i_arg1};
    assign dif_w = {1'b0, i_arg0} - {1'b0, i_arg1};

    // Opcode decode: select the result and raw carry/overflow, then derive N/Z.
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (i_oper)
            OP_ADD: begin
                res_c = sum_w[WIDTH-1:0];
                c_c   = sum_w[WIDTH];
                v_c   = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) &&
                        (sum_w[WIDTH-1] != i_arg0[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (v_c)
                    res_c = sat_value(i_arg0[WIDTH-1]);
`endif
            end
            OP_SUB: begin
                res_c = dif_w[WIDTH-1:0];
                c_c   = dif_w[WIDTH];
                v_c   = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) &&
                        (dif_w[WIDTH-1] != i_arg0[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (v_c)
                    res_c = sat_value(i_arg0[WIDTH-1]);
`endif
            end
            OP_AND:  res_c = i_arg0 & i_arg1;
            OP_SHL: begin
                res_c = shl_res;
                c_c   = shl_c;
                v_c   = shl_v;
            end
            OP_SRA: begin
                res_c = sra_res;
                c_c   = sra_c;
            end
            OP_PASS: res_c = i_arg0;
            OP_OR:   res_c = i_arg0 | i_arg1;
            OP_XOR:  res_c = i_arg0 ^ i_arg1;
            default: res_c = '0;
        endcase

        flag_c         = '0;
        flag_c[FLAG_V] = v_c;
        flag_c[FLAG_C] = c_c;
        flag_c[FLAG_N] = res_c[WIDTH-1];
        flag_c[FLAG_Z] = (res_c == '0);
    end

    // Stage p0 -> p1: capture result and flags every clock; reset clears both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_p1 <= '0;
            flag_p1   <= '0;
        end else begin
            result_p1 <= res_c;
            flag_p1   <= flag_c;
        end
    end

    assign o_result = result_p1;
    assign o_flag   = flag_p1;

endmodule

// File: tb/tb_alu10.sv
// Directed self-checking bench for alu10: reset behaviour, each opcode,
// shift/overflow boundaries and a back-to-back opcode sweep.
module tb_alu10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [9:0] arg0;
    logic signed [9:0] arg1;
    logic        [2:0] oper;
    logic signed [9:0] result;
    logic        [3:0] flag;

    int errors = 0;
    int checks = 0;

    logic signed [9:0] pipe_r [8];
    logic        [3:0] pipe_f [8];

    alu10 dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_arg0   (arg0),
        .i_arg1   (arg1),
        .i_oper   (oper),
        .o_result (result),
        .o_flag   (flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [9:0] er, input logic [3:0] ef);
        checks++;
        assert ({result, flag} === {er, ef}) else begin
            errors++;
            $error("FAIL %s: observed result=%0d flags=%b expected result=%0d flags=%b",
                   tag, result, flag, er, ef);
        end
    endtask

    // Apply one operation, let one edge capture it, then sample 1 time unit later.
    task automatic apply(input logic [2:0] op, input logic signed [9:0] a,
                         input logic signed [9:0] b);
        oper = op;
        arg0 = a;
        arg1 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        oper  = 3'b000;
        arg0  = 10'sd5;
        arg1  = 10'sd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 10'sd0, 4'b0000);
        rst_n = 1'b1;

        apply(3'b000, -10'sd512, -10'sd512);
`ifdef ALU_SAT_EN
        check("add_neg_ovf", -10'sd512, 4'b1110);
`else
        check("add_neg_ovf", 10'sd0, 4'b1101);
`endif
        apply(3'b000, 10'sd0, 10'sd1);
        check("add_0_1", 10'sd1, 4'b0000);
        apply(3'b001, 10'sd1, 10'sd10);
        check("sub_1_10", -10'sd9, 4'b0110);
        apply(3'b001, 10'sd8, 10'sd8);
        check("sub_8_8", 10'sd0, 4'b0001);
        apply(3'b011, 10'sd2, 10'sd1);
        check("shl_2_1", 10'sd4, 4'b0000);
        apply(3'b011, 10'sd256, 10'sd1);
        check("shl_256_1", -10'sd512, 4'b1010);
        apply(3'b100, -10'sd8, -10'sd14);
        check("sra_m8_2", -10'sd2, 4'b0010);
        apply(3'b100, -10'sd8, 10'sd10);
        check("sra_m8_10", -10'sd1, 4'b0110);
        apply(3'b011, 10'sd0, 10'sd15);
        check("shl_n15", 10'sd0, 4'b0001);
        apply(3'b011, 10'sd1, 10'sd10);
        check("shl_1_10", 10'sd0, 4'b1101);
        apply(3'b010, 10'sd5, 10'sd3);
        check("and_5_3", 10'sd1, 4'b0000);
        apply(3'b110, 10'sd7, 10'sd2);
        check("or_7_2", 10'sd7, 4'b0000);
        apply(3'b111, 10'sd7, 10'sd2);
        check("xor_7_2", 10'sd5, 4'b0000);
        apply(3'b101, -10'sd3, -10'sd100);
        check("pass_m3", -10'sd3, 4'b0010);

        // Back-to-back sweep over all opcodes with A=-3, B=2.
        pipe_r[0] = -10'sd1;  pipe_f[0] = 4'b0010;
        pipe_r[1] = -10'sd5;  pipe_f[1] = 4'b0010;
        pipe_r[2] = 10'sd0;   pipe_f[2] = 4'b0001;
        pipe_r[3] = -10'sd12; pipe_f[3] = 4'b0110;
        pipe_r[4] = -10'sd1;  pipe_f[4] = 4'b0010;
        pipe_r[5] = -10'sd3;  pipe_f[5] = 4'b0010;
        pipe_r[6] = -10'sd1;  pipe_f[6] = 4'b0010;
        pipe_r[7] = -10'sd1;  pipe_f[7] = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), -10'sd3, 10'sd2);
            check($sformatf("pipe_op%0d", i), pipe_r[i], pipe_f[i]);
        end

        // Mid-stream reset: outputs must clear before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 10'sd0, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held_edge", 10'sd0, 4'b0000);
        rst_n = 1'b1;
        apply(3'b000, 10'sd0, 10'sd1);
        check("after_reset_add", 10'sd1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu10.md
Name: alu10

Overview:
- Registered 10-bit signed ALU: add, subtract, AND, OR, XOR, shift-left and arithmetic shift-right on two operands, plus 4 status flags.
- Pure datapath leaf; a new operation is sampled every clock and its result and flags are presented one cycle later.
- Used by the execution stage of the small-CPU datapath.

Parameters:
- WIDTH, 10, operand/result width in bits (two's complement). All behaviour below is stated for WIDTH=10; the shift-amount field is clog2(WIDTH) bits.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_arg0  in  WIDTH  signed operand A
- i_arg1  in  WIDTH  signed operand B; for shifts, i_arg1[3:0] is the unsigned shift amount
- i_oper  in  3  opcode
- o_result  out  WIDTH  signed result, registered
- o_flag  out  4  {V, C, N, Z}; [3] overflow, [2] carry/borrow, [1] negative, [0] zero; registered

Behaviour:
- Reset: while i_rst_n=0, o_result=0 and o_flag=0 asynchronously. The first capture happens on the first rising edge after deassertion.
- Latency: 1 cycle. Inputs are sampled on each rising i_clk; o_result/o_flag update on that edge. There is no handshake and no enable, so every cycle is a new operation. Back-to-back opcodes are fully pipelined (throughput 1/cycle).
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND: A&B
  - 011 SHL: A << n
  - 100 SRA: A >>> n (sign fill)
  - 101 PASS: result=A
  - 110 OR: A|B
  - 111 XOR: A^B
- Arithmetic: computed at WIDTH+1 bits; the result is the low WIDTH bits (wrap-around).
  - ADD: C=carry-out of the unsigned sum. V=1 when operand signs are equal and the result sign differs.
  - SUB: C=borrow, i.e. 1 when unsigned A < unsigned B. V=1 when operand signs differ and the result sign differs from A.
  - Example: -512 + -512 gives result 0, Z=1, C=1, V=1, N=0.
- Shifts: n = i_arg1[3:0] (unsigned); i_arg1[9:4] is ignored.
  - n=0: result=A, C=0.
  - SHL with 1≤n≤10: C = last bit shifted out (A[10-n]). n≥11: result 0, C=0.
  - SRA with 1≤n≤10: C = A[n-1]. n≥10: result is all sign bits.
  - SHL: V=1 when A·2^n is not representable in signed WIDTH bits. SRA: V=0.
- Logic ops and PASS: C=0, V=0.
- N = result[WIDTH-1] and Z = (result==0) for every opcode, evaluated on the final (possibly saturated) result.
- Opcode changes with operands held: the new result appears after the next edge. No X propagation from the unused i_arg1 bits.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD/SUB saturate on overflow. Positive overflow gives +511; negative overflow gives -512. V is still reported as 1; C is unchanged (raw carry/borrow).
- Undefined: wrap-around as above. Other opcodes are unaffected in both builds.

Decomposition:
- Package alu10_pkg: opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_SHL, OP_SRA, OP_PASS, OP_OR, OP_XOR), flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), saturation constants.
- One sub-module is natural: alu10_shifter. It is combinational, computes SHL/SRA result, C and V, and is instantiated once.
- The adder/subtractor, logic ops, flag generation and output registers live in alu10.

Test Plan:
- Reset: hold i_rst_n=0 with nonzero inputs -> o_result=0, o_flag=0000. Assert reset mid-stream -> outputs clear immediately, without waiting for an edge.
- ADD: A=-512, B=-512 -> result 0, flags 1101 (V,C,Z). A=0, B=1 -> result 1, flags 0000. With ALU_SAT_EN: -512+-512 -> result -512, flags 1110.
- SUB: 1-10 -> result -9, flags 0110 (C borrow, N). 8-8 -> result 0, flags 0001.
- Shifts:
  - SHL 2<<1 -> result 4, flags 0000.
  - SHL 256<<1 -> result -512, flags 1010 (V, N).
  - SRA -8>>>2 -> result -2, flags 0010.
  - SHL with n=15 -> result 0, flags 0001.
- Logic: 5&3 -> 1, flags 0000. 7|2 -> 7, flags 0000. 7^2 -> 5, flags 0000. PASS -3 -> -3, flags 0010.
- Pipelining: change opcode every cycle across all 8 codes -> each result appears exactly one edge after its inputs, with no bubbles.
